// File: rtl/rx_pkg.sv
// rx_pkg: shared K-chars, abort cause codes and framer states for the RX frame packer
package rx_pkg;
  localparam logic [7:0] KC_SOF = 8'hFB;
  localparam logic [7:0] KC_EOF = 8'hFD;
  localparam logic [7:0] KC_IDLE = 8'hBC;
  localparam logic [1:0] ABORT_SYNC = 2'b01;
  localparam logic [1:0] ABORT_OVF = 2'b10;
  localparam logic [1:0] ABORT_PROTO = 2'b11;
  typedef enum logic [1:0] {HUNT, FRAME, FLUSH} state_t;
endpackage

// File: rtl/rx_commit_fifo.sv
// rx_commit_fifo: FWFT FIFO whose writes stay invisible until committed and can be rolled back
module rx_commit_fifo #(
  parameter int W = 33,
  parameter int DEPTH = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we,
  input  logic [W-1:0]             wdata,
  input  logic                     mark,
  input  logic                     rollback,
  input  logic                     commit,
  input  logic                     rd,
  output logic [W-1:0]             rdata,
  output logic                     valid,
  output logic                     pending,
  output logic                     full_tent,
  output logic                     full_commit,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW:0] tent, cmt, rdp, base, tm1;
  assign base = rollback ? cmt : tent;
  assign tm1 = tent - 1'b1;
  assign valid = cmt != rdp;
  assign pending = tent != cmt;
  assign level = cmt - rdp;
  assign full_tent = (tent - rdp) == (AW+1)'(DEPTH);
  assign full_commit = (cmt - rdp) == (AW+1)'(DEPTH);
  assign rdata = valid ? mem[rdp[AW-1:0]] : '0;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      tent <= '0;
      cmt <= '0;
      rdp <= '0;
    end else begin
      tent <= base + (AW+1)'(we);
      if (commit) cmt <= base + (AW+1)'(we);
      if (rd && valid) rdp <= rdp + 1'b1;
    end
  // a frame ending on a word boundary gets its last flag set after the fact
  always_ff @(posedge clk)
    if (we) mem[base[AW-1:0]] <= wdata;
    else if (mark) mem[tm1[AW-1:0]][W-1] <= 1'b1;
endmodule

// File: rtl/rx_frame_packer.sv
// rx_frame_packer: delineates K-char framed RX bytes, packs payload into words and commits whole frames
module rx_frame_packer
  import rx_pkg::*;
#(
  parameter int LANE_BYTES = 2,
  parameter int OUT_BYTES = 4,
  parameter int DEPTH = 64,
  parameter logic [7:0] K_SOF = KC_SOF,
  parameter logic [7:0] K_EOF = KC_EOF,
  parameter logic [7:0] K_IDLE = KC_IDLE
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [8*LANE_BYTES-1:0]  rx_data,
  input  logic [LANE_BYTES-1:0]    rx_datak,
  input  logic [LANE_BYTES-1:0]    rx_syncstatus,
  output logic [8*OUT_BYTES-1:0]   out_data,
  output logic                     out_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     in_frame,
  output logic [15:0]              frame_cnt,
  output logic [15:0]              abort_cnt,
  output logic [1:0]               abort_cause
);
  localparam int ACC = OUT_BYTES + LANE_BYTES - 1;
  localparam int CW = $clog2(ACC + 1);
  localparam int OW = 8 * OUT_BYTES;
  logic [8*LANE_BYTES-1:0] d_q;
  logic [LANE_BYTES-1:0] k_q, s_q;
  state_t state, state_n;
  logic [8*ACC-1:0] acc, acc_n;
  logic [CW-1:0] cnt;
  int cnt_n;
  logic [OW-1:0] wdata;
  logic [7:0] b;
  logic [1:0] cause_n;
  logic we, wlast, mark, rollback, commit, eof, done, pending, full_tent, full_commit;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      d_q <= '0;
      k_q <= '0;
      s_q <= '0;
    end else begin
      d_q <= rx_data;
      k_q <= rx_datak;
      s_q <= rx_syncstatus;
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= HUNT;
    else state <= state_n;
  always_comb begin
    state_n = state;
    acc_n = acc;
    cnt_n = int'(cnt);
    we = 1'b0;
    wlast = 1'b0;
    wdata = '0;
    mark = 1'b0;
    rollback = 1'b0;
    commit = 1'b0;
    cause_n = 2'b00;
    eof = 1'b0;
    done = 1'b0;
    b = '0;
    if (state == FLUSH) begin
      acc_n = '0;
      cnt_n = 0;
      state_n = HUNT;
      if (full_tent) begin
        cause_n = ABORT_OVF;
        rollback = 1'b1;
      end else begin
        we = 1'b1;
        wlast = 1'b1;
        wdata = acc[OW-1:0];
        commit = 1'b1;
      end
    end else if (state == FRAME && !(&s_q)) begin
      cause_n = ABORT_SYNC;
      rollback = 1'b1;
      acc_n = '0;
      cnt_n = 0;
      state_n = HUNT;
    end else begin
      for (int i = 0; i < LANE_BYTES; i++) begin
        b = d_q[8*i +: 8];
        if (!done) begin
          if (state_n == HUNT) begin
            if (i == 0 && k_q[0] && b == K_SOF && (&s_q)) state_n = FRAME;
          end else if (!k_q[i]) begin
            acc_n[8*cnt_n +: 8] = b;
            cnt_n++;
          end else if (b == K_EOF) begin
            eof = 1'b1;
            done = 1'b1;
          end else if (b != K_IDLE) begin
            // an SOF here restarts the frame; any other K-char drops to HUNT
            cause_n = ABORT_PROTO;
            rollback = 1'b1;
            acc_n = '0;
            cnt_n = 0;
            if (b != K_SOF) begin
              state_n = HUNT;
              done = 1'b1;
            end
          end
        end
      end
      if (state_n == FRAME && (cnt_n >= OUT_BYTES || (eof && cnt_n > 0))) begin
        if (rollback ? full_commit : full_tent) begin
          cause_n = ABORT_OVF;
          rollback = 1'b1;
          acc_n = '0;
          cnt_n = 0;
          state_n = HUNT;
        end else begin
          we = 1'b1;
          wdata = acc_n[OW-1:0];
          acc_n = acc_n >> OW;
          cnt_n = cnt_n > OUT_BYTES ? cnt_n - OUT_BYTES : 0;
          wlast = eof && cnt_n == 0;
          commit = wlast;
          state_n = !eof ? FRAME : (cnt_n == 0 ? HUNT : FLUSH);
        end
      end else if (state_n == FRAME && eof) begin
        mark = pending && !rollback;
        commit = mark;
        state_n = HUNT;
      end
    end
  end
  always_comb in_frame = state == FRAME;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      acc <= '0;
      cnt <= '0;
      frame_cnt <= '0;
      abort_cnt <= '0;
      abort_cause <= '0;
    end else begin
      acc <= acc_n;
      cnt <= CW'(cnt_n);
      if (commit) frame_cnt <= frame_cnt + 16'd1;
      if (cause_n != 2'b00) begin
        abort_cause <= cause_n;
        abort_cnt <= abort_cnt + 16'(abort_cnt != 16'hFFFF);
      end
    end
  rx_commit_fifo #(.W(OW + 1), .DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .we(we),
    .wdata({wlast, wdata}),
    .mark(mark),
    .rollback(rollback),
    .commit(commit),
    .rd(out_ready),
    .rdata({out_last, out_data}),
    .valid(out_valid),
    .pending(pending),
    .full_tent(full_tent),
    .full_commit(full_commit),
    .level(fifo_level)
  );
endmodule

// File: doc/rx_frame_packer.md
Name: rx_frame_packer

Overview:
Parametrised successor to the fixed 16-bit RX buffer controller. Sits behind the 8b/10b-decoded transceiver RX parallel interface.
- Delineates frames using K-character delimiters and strips idles.
- Packs payload bytes into OUT_BYTES-wide words.
- Stores words in a frame-atomic FIFO: a frame becomes readable only after it completes cleanly; aborted frames are rolled back.
- Presents a valid/ready read port toward the DRAM writer, plus frame and abort statistics.

Parameters:
LANE_BYTES, 2, bytes per RX parallel word (1..8)
OUT_BYTES, 4, bytes per output word (>= LANE_BYTES, <= 16)
DEPTH, 64, FIFO depth in output words (power of 2)
K_SOF, 8'hFB, start-of-frame K-char (K27.7)
K_EOF, 8'hFD, end-of-frame K-char (K29.7)
K_IDLE, 8'hBC, idle/clock-compensation K-char (K28.5)

Ports:
clk  in  1  single clock; rx_std_clkout domain
rst  in  1  asynchronous, active-high reset
rx_data  in  8*LANE_BYTES  decoded bytes; byte i = rx_data[8i+7:8i], byte 0 received first
rx_datak  in  LANE_BYTES  per-byte K flag
rx_syncstatus  in  LANE_BYTES  per-byte word-aligner sync
out_data  out  8*OUT_BYTES  packed payload; first byte in [7:0]
out_last  out  1  word is final word of its frame
out_valid  out  1  committed word available (first-word-fall-through)
out_ready  in  1  consumer accepts word when out_valid & out_ready
fifo_level  out  clog2(DEPTH)+1  committed, unread words
in_frame  out  1  framer is in FRAME state
frame_cnt  out  16  committed frames, wraps
abort_cnt  out  16  aborted frames, saturates at 16'hFFFF
abort_cause  out  2  last abort: 01 sync loss, 10 overflow, 11 protocol (SOF in frame / unknown K)

Behaviour:
- Reset: all outputs 0. State HUNT. Pointers, accumulator and counters cleared. Reset mid-frame discards everything, committed words included.
- Stage 0: the input is registered. Stage 1: framing, packing and FIFO write. Everything below describes Stage 1 operating on the registered word.
- HUNT:
  - Aligned means &rx_syncstatus.
  - Byte 0 == K_SOF with K set and aligned: go to FRAME; latch wr_tent = wr_commit.
  - Remaining bytes of the same word are processed as FRAME bytes.
  - SOF in any byte other than 0 is ignored. All other bytes are ignored.
- FRAME, per byte in ascending order:
  - Data byte (K=0): append to accumulator.
  - K_IDLE: skipped.
  - K_EOF: end of frame; later bytes in this word are ignored.
  - K_SOF: protocol abort, then immediately start a new frame from this word.
  - Any other K-char: protocol abort; bytes after it are ignored.
  - Any syncstatus bit low: sync-loss abort for the whole word; nothing appended.
- Packing:
  - The accumulator holds up to OUT_BYTES+LANE_BYTES-1 bytes.
  - When it reaches OUT_BYTES bytes, write one word at wr_tent, advance wr_tent, shift out the used bytes.
  - At most one word is written per cycle (guaranteed because OUT_BYTES >= LANE_BYTES).
- EOF:
  - Remaining partial bytes are flushed as a final zero-padded word with last=1.
  - If a full word is also due that cycle, the full word is written that cycle and the flush happens the next cycle; input is ignored during that flush cycle.
  - If the word written on EOF is full and no bytes remain, it carries last=1 itself.
  - Commit: wr_commit = wr_tent, frame_cnt+1, return to HUNT.
  - Empty frame (no payload bytes): nothing written or counted; not an abort.
- Overflow: a write is needed but wr_tent - rd_ptr == DEPTH gives an overflow abort. Frames longer than DEPTH words therefore always abort.
- Abort:
  - wr_tent = wr_commit; accumulator cleared; abort_cnt+1 (saturating); abort_cause updated; go to HUNT.
  - Exception: an SOF-triggered abort re-enters FRAME in the same cycle.
- Read side:
  - out_valid = (wr_commit != rd_ptr). out_data/out_last come from the memory at rd_ptr.
  - rd_ptr advances on out_valid & out_ready.
  - Reads never observe uncommitted words.
  - A read and a commit in the same cycle are both honoured; fifo_level is updated accordingly.
- Latency: if EOF is presented at the input in cycle N, out_valid rises in cycle N+2. Add one cycle if a flush cycle was required.
- Pointers are clog2(DEPTH)+1 bits wide; the extra MSB distinguishes full from empty.

Decomposition:
- Shared package rx_pkg holds:
  - K-char constants.
  - abort_cause encodings: ABORT_SYNC, ABORT_OVF, ABORT_PROTO.
  - State enum: HUNT, FRAME, FLUSH.
- One sub-module, rx_commit_fifo:
  - Dual-pointer memory with tentative write pointer, commit and rollback, FWFT read.
  - Width 8*OUT_BYTES+1, depth DEPTH.

Test Plan:
- Defaults. Input {16'h00FB,k=01}, {16'h2211,k=00}, {16'hFD33,k=10} -> one word: out_data=32'h33221100, out_last=1, frame_cnt=1, appearing 2 cycles after the EOF cycle.
- 5-byte payload with K_IDLE inserted mid-frame -> two words; the second is zero-padded with last=1; the idle is absent from the output.
- syncstatus=2'b01 for one cycle mid-frame -> no output; abort_cnt=1, abort_cause=01, fifo_level unchanged, previously committed frame still readable.
- DEPTH=4, 20-byte frame with out_ready=0 -> abort_cause=10, fifo_level=0. A following 4-byte frame commits (fifo_level=1).
- SOF inside a frame -> first frame discarded, abort_cause=11; the second frame commits correctly.
- out_ready toggled randomly across 100 random frames -> scoreboard byte-exact, with last flags matching frame boundaries. Then assert rst mid-frame -> all outputs 0 on the next edge.
